// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two cache request ports and the memory bus of
// mem_arbiter.
//   i_* / d_*  : instruction / data cache port (req, we, a, wd in; rd, ack out)
//   mem_*      : block-wide main-memory port (re, we, a, wd out; rd, valid in)
// Modports:
//   master : requester/memory side (caches and memory model)
//   slave  : arbiter side
interface mem_arbiter_if #(
    parameter int BLOCKSIZE = 4
);
    logic                   i_req;
    logic                   i_we;
    logic [31:0]            i_a;
    logic [BLOCKSIZE*32-1:0] i_wd;
    logic [BLOCKSIZE*32-1:0] i_rd;
    logic                   i_ack;

    logic                   d_req;
    logic                   d_we;
    logic [31:0]            d_a;
    logic [BLOCKSIZE*32-1:0] d_wd;
    logic [BLOCKSIZE*32-1:0] d_rd;
    logic                   d_ack;

    logic                   mem_re;
    logic                   mem_we;
    logic [31:0]            mem_a;
    logic [BLOCKSIZE*32-1:0] mem_wd;
    logic [BLOCKSIZE*32-1:0] mem_rd;
    logic                   mem_valid;

    modport master (
        output i_req, i_we, i_a, i_wd,
        input  i_rd, i_ack,
        output d_req, d_we, d_a, d_wd,
        input  d_rd, d_ack,
        input  mem_re, mem_we, mem_a, mem_wd,
        output mem_rd, mem_valid
    );

    modport slave (
        input  i_req, i_we, i_a, i_wd,
        output i_rd, i_ack,
        input  d_req, d_we, d_a, d_wd,
        output d_rd, d_ack,
        output mem_re, mem_we, mem_a, mem_wd,
        input  mem_rd, mem_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main memory between the instruction
// cache (port I) and the data cache (port D). One block transaction at a time,
// round-robin on ties, back-to-back handoff when the other port is waiting,
// and a watchdog that aborts a grant the memory never completes.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous, active-low
//   bus         : mem_arbiter_if.slave (cache ports + memory port)
//   busy        : high while a port is granted
//   timeout_err : sticky, set by any watchdog abort
module mem_arbiter #(
    parameter int BLOCKSIZE = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          timeout_err
);
    localparam int W  = BLOCKSIZE * 32;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t        state, state_nx;
    port_t         last_grant;
    logic [CW-1:0] cnt;
    logic          grant_i, grant_d, go_idle, abort, ack_i, ack_d;
    logic          mem_re_q, mem_we_q;
    logic [31:0]   mem_a_q;
    logic [W-1:0]  mem_wd_q;

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        go_idle  = 1'b0;
        abort    = 1'b0;
        ack_i    = 1'b0;
        ack_d    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that was not served last wins.
                if (bus.i_req && (!bus.d_req || last_grant == PORT_D))
                    grant_i = 1'b1;
                else if (bus.d_req)
                    grant_d = 1'b1;
            end
            GRANT_I: begin
                // A completion in the last watchdog cycle beats the abort.
                if (bus.mem_valid) begin
                    ack_i = 1'b1;
                    if (bus.d_req) grant_d = 1'b1;
                    else           go_idle = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    ack_i   = 1'b1;
                    abort   = 1'b1;
                    go_idle = 1'b1;
                end
            end
            GRANT_D: begin
                if (bus.mem_valid) begin
                    ack_d = 1'b1;
                    if (bus.i_req) grant_i = 1'b1;
                    else           go_idle = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    ack_d   = 1'b1;
                    abort   = 1'b1;
                    go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase
        if (grant_i)      state_nx = GRANT_I;
        else if (grant_d) state_nx = GRANT_D;
        else if (go_idle) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= PORT_I;
            cnt         <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_i) begin
                mem_a_q    <= bus.i_a;
                mem_wd_q   <= bus.i_wd;
                mem_re_q   <= ~bus.i_we;
                mem_we_q   <= bus.i_we;
                last_grant <= PORT_I;
                cnt        <= '0;
            end else if (grant_d) begin
                mem_a_q    <= bus.d_a;
                mem_wd_q   <= bus.d_wd;
                mem_re_q   <= ~bus.d_we;
                mem_we_q   <= bus.d_we;
                last_grant <= PORT_D;
                cnt        <= '0;
            end else if (go_idle) begin
                mem_re_q <= 1'b0;
                mem_we_q <= 1'b0;
                cnt      <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + CW'(1);
            end
            if (abort) timeout_err <= 1'b1;
        end
    end

    assign bus.i_ack  = ack_i;
    assign bus.d_ack  = ack_d;
    assign bus.i_rd   = (abort && ack_i) ? '0 : bus.mem_rd;
    assign bus.d_rd   = (abort && ack_d) ? '0 : bus.mem_rd;
    assign bus.mem_re = mem_re_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_a  = mem_a_q;
    assign bus.mem_wd = mem_wd_q;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Requests are queued per
// port; the expected grant order is pushed to a scoreboard and popped on each
// ack. A memory stub answers after stub_lat enabled cycles.
module tb_mem_arbiter;
    localparam int BS = 4;
    localparam int TO = 8;
    localparam int W  = BS * 32;

    logic clk = 1'b0;
    logic reset;
    logic busy, timeout_err;

    always #5 clk = ~clk;

    mem_arbiter_if #(.BLOCKSIZE(BS)) bus ();

    mem_arbiter #(.BLOCKSIZE(BS), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    typedef struct {
        bit           we;
        logic [31:0]  a;
        logic [W-1:0] wd;
    } req_t;

    typedef struct {
        bit           port;   // 0 = I, 1 = D
        bit           we;
        logic [31:0]  a;
        logic [W-1:0] wd;
        bit           abort;
        int           lat;
    } exp_t;

    req_t iq[$], dq[$];
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int scnt = 0;
    int stub_lat = 4;
    bit stub_on = 1'b1;
    int gc = 0;
    bit chk_next = 1'b0;
    bit want_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pattern(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a + 32'h0000_1111, ~a, {a[15:0], a[31:16]}};
    endfunction

    task automatic issue(input bit port, input bit we, input logic [31:0] a, input logic [W-1:0] wd);
        req_t r;
        r.we = we; r.a = a; r.wd = wd;
        if (port) dq.push_back(r);
        else      iq.push_back(r);
    endtask

    task automatic expect_txn(input bit port, input bit we, input logic [31:0] a,
                              input logic [W-1:0] wd, input bit abort, input int lat);
        exp_t e;
        e.port = port; e.we = we; e.a = a; e.wd = wd; e.abort = abort; e.lat = lat;
        sb.push_back(e);
    endtask

    // One clock: memory stub after the rising edge, monitor + requesters at
    // the falling edge.
    task automatic tick();
        exp_t e;
        req_t r;
        logic [W-1:0] rd;
        @(posedge clk);
        #1;
        if (stub_on) begin
            if (bus.mem_valid) begin
                bus.mem_valid = 1'b0;
                scnt = 0;
            end
            if (bus.mem_re || bus.mem_we) scnt++;
            else                          scnt = 0;
            if (scnt == stub_lat) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd    = pattern(bus.mem_a);
            end
        end
        @(negedge clk);
        if (chk_next) begin
            check_eq("busy_after_ack", busy, want_busy);
            chk_next = 1'b0;
        end
        check_eq("dual_ack", bus.i_ack & bus.d_ack, 0);
        if (bus.mem_re || bus.mem_we) gc++;
        if (bus.i_ack || bus.d_ack) begin
            if (sb.size() == 0) begin
                check_eq("spurious_ack", {bus.i_ack, bus.d_ack}, 0);
            end else begin
                e = sb.pop_front();
                check_eq("ack_port", bus.d_ack, e.port);
                check_eq("mem_a", bus.mem_a, e.a);
                check_eq("mem_we", bus.mem_we, e.we);
                check_eq("mem_re", bus.mem_re, !e.we);
                if (e.we) check_eq("mem_wd", bus.mem_wd, e.wd);
                rd = e.port ? bus.d_rd : bus.i_rd;
                check_eq("rd", rd, e.abort ? '0 : pattern(e.a));
                check_eq("ack_cycle", gc, e.lat);
                chk_next  = 1'b1;
                want_busy = !e.abort && (e.port ? bus.i_req : bus.d_req);
            end
            gc = 0;
        end
        if (bus.i_ack) bus.i_req = 1'b0;
        if (bus.d_ack) bus.d_req = 1'b0;
        if (!bus.i_req && iq.size() > 0) begin
            r = iq.pop_front();
            bus.i_req = 1'b1; bus.i_we = r.we; bus.i_a = r.a; bus.i_wd = r.wd;
        end
        if (!bus.d_req && dq.size() > 0) begin
            r = dq.pop_front();
            bus.d_req = 1'b1; bus.d_we = r.we; bus.d_a = r.a; bus.d_wd = r.wd;
        end
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while ((sb.size() > 0 || iq.size() > 0 || dq.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) check_eq("wait_bound", sb.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        gc = 0;
        chk_next = 1'b0;
        tick();
    endtask

    initial begin
        logic [W-1:0] wblk;
        int n;
        reset = 1'b0;
        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_a = '0; bus.i_wd = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_a = '0; bus.d_wd = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0;
        tick();
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_acks", {bus.i_ack, bus.d_ack}, 0);
        check_eq("rst_en", {bus.mem_re, bus.mem_we}, 0);
        check_eq("rst_mem_a", bus.mem_a, 0);
        check_eq("rst_mem_wd", bus.mem_wd, 0);
        check_eq("rst_err", timeout_err, 0);
        reset = 1'b1;
        tick();

        // Single read on I
        issue(0, 0, 32'h100, '0);
        expect_txn(0, 0, 32'h100, '0, 0, 4);
        tick();
        tick();
        check_eq("rd_t1_re", bus.mem_re, 1);
        check_eq("rd_t1_a", bus.mem_a, 32'h100);
        check_eq("rd_t1_busy", busy, 1);
        run_idle(50);
        check_eq("rd_idle_re", bus.mem_re, 0);

        // Single write on D
        wblk = {32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};
        issue(1, 1, 32'h2040, wblk);
        expect_txn(1, 1, 32'h2040, wblk, 0, 4);
        tick();
        tick();
        check_eq("wr_t1_en", {bus.mem_re, bus.mem_we}, 2'b01);
        check_eq("wr_t1_wd", bus.mem_wd, wblk);
        run_idle(50);
        check_eq("wr_idle_we", bus.mem_we, 0);

        // Tie after reset: D, then I back-to-back, then another tie to D
        do_reset();
        issue(1, 0, 32'h1000, '0);
        issue(0, 0, 32'h2000, '0);
        expect_txn(1, 0, 32'h1000, '0, 0, 4);
        expect_txn(0, 0, 32'h2000, '0, 0, 4);
        run_idle(60);
        issue(1, 1, 32'h1100, pattern(32'h77));
        issue(0, 0, 32'h2100, '0);
        expect_txn(1, 1, 32'h1100, pattern(32'h77), 0, 4);
        expect_txn(0, 0, 32'h2100, '0, 0, 4);
        run_idle(60);

        // Alternation with both ports continuously requesting
        for (int k = 0; k < 3; k++) begin
            issue(1, k[0], 32'h3000 + 32'(k) * 32'h40, pattern(32'(k)));
            issue(0, 0, 32'h4000 + 32'(k) * 32'h40, '0);
        end
        for (int k = 0; k < 3; k++) begin
            expect_txn(1, k[0], 32'h3000 + 32'(k) * 32'h40, pattern(32'(k)), 0, 4);
            expect_txn(0, 0, 32'h4000 + 32'(k) * 32'h40, '0, 0, 4);
        end
        run_idle(150);

        // Watchdog abort, then sticky error across a normal transaction
        check_eq("err_before", timeout_err, 0);
        stub_lat = 1000;
        issue(0, 0, 32'h300, '0);
        expect_txn(0, 0, 32'h300, '0, 1, TO);
        run_idle(50);
        check_eq("err_set", timeout_err, 1);
        stub_lat = 4;
        issue(1, 0, 32'h400, '0);
        expect_txn(1, 0, 32'h400, '0, 0, 4);
        run_idle(50);
        check_eq("err_sticky", timeout_err, 1);
        do_reset();
        check_eq("err_cleared", timeout_err, 0);

        // Completion in exactly the last watchdog cycle wins
        stub_lat = TO;
        issue(0, 0, 32'h500, '0);
        expect_txn(0, 0, 32'h500, '0, 0, TO);
        run_idle(50);
        check_eq("err_edge", timeout_err, 0);

        // Reset in the middle of a D grant
        stub_lat = 1000;
        wblk = pattern(32'h600);
        issue(1, 1, 32'h600, wblk);
        tick();
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        check_eq("mid_busy", busy, 1);
        tick();
        tick();
        reset = 1'b0;
        bus.d_req = 1'b0;
        stub_on = 1'b0;
        bus.mem_valid = 1'b0;
        tick();
        gc = 0;
        check_eq("mid_busy0", busy, 0);
        check_eq("mid_acks", {bus.i_ack, bus.d_ack}, 0);
        check_eq("mid_en", {bus.mem_re, bus.mem_we}, 0);
        check_eq("mid_mem_a", bus.mem_a, 0);
        check_eq("mid_mem_wd", bus.mem_wd, 0);
        check_eq("mid_err", timeout_err, 0);
        reset = 1'b1;
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_rd = pattern(32'h600);
        tick();
        check_eq("late_valid_ack", {bus.i_ack, bus.d_ack}, 0);
        check_eq("late_valid_busy", busy, 0);
        bus.mem_valid = 1'b0;
        scnt = 0;
        stub_on = 1'b1;
        stub_lat = 4;
        tick();

        // First tie after the mid-grant reset goes to D again
        issue(1, 0, 32'h700, '0);
        issue(0, 0, 32'h800, '0);
        expect_txn(1, 0, 32'h700, '0, 0, 4);
        expect_txn(0, 0, 32'h800, '0, 0, 4);
        run_idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single block-wide main-memory model between the instruction cache (port I) and data cache (port D) on a cache-miss refill or writeback. It accepts one block transaction at a time from either port and presents it to memory on `mem_re`/`mem_we`, `mem_a` and `mem_wd`. It returns the memory's `mem_valid` completion to the granted port as a one-cycle acknowledge. Ties are resolved round-robin, and a watchdog aborts any transaction the memory never completes.

## Interface
- `BLOCKSIZE`, 4: words per block; data buses are `BLOCKSIZE*32` bits.
- `TIMEOUT`, 64: maximum cycles a grant waits for `mem_valid` before abort; must be ≥ 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_req`, `d_req`  in  1  transaction request; held high until the cycle of the port's ack.
- `i_we`, `d_we`  in  1  1 = block write, 0 = block read.
- `i_a`, `d_a`  in  32  byte address; memory uses the block address bits.
- `i_wd`, `d_wd`  in  BLOCKSIZE*32  write block.
- `i_rd`, `d_rd`  out  BLOCKSIZE*32  read block; valid only with the port's ack.
- `i_ack`, `d_ack`  out  1  one-cycle completion pulse.
- `mem_re`, `mem_we`  out  1  memory read / write enables (registered).
- `mem_a`  out  32  memory address (registered).
- `mem_wd`  out  BLOCKSIZE*32  memory write block (registered).
- `mem_rd`  in  BLOCKSIZE*32  memory read block.
- `mem_valid`  in  1  memory completion, high one cycle.
- `busy`  out  1  high while in a GRANT state.
- `timeout_err`  out  1  sticky; set on any watchdog abort.

## Operation
- **States:**
  - IDLE, GRANT_I, GRANT_D.
  - `last_grant` register records the last-served port.
  - Watchdog counter `cnt` is `$clog2(TIMEOUT)+1` bits.
- **IDLE:**
  - Only `i_req`: go to GRANT_I.
  - Only `d_req`: go to GRANT_D.
  - Both: grant the port not equal to `last_grant`.
  - Neither: stay in IDLE.
  - `mem_valid` in IDLE is ignored; no ack is generated.
- **On entering GRANT_x:**
  - Capture `x_a` into `mem_a` and `x_wd` into `mem_wd`.
  - Set `mem_re = ~x_we`, `mem_we = x_we`.
  - Set `last_grant = x` and `cnt = 0`.
  - Memory outputs stay constant for the whole grant.
- **In GRANT_x with `mem_valid` = 1:**
  - `x_ack = 1` combinationally; `x_rd = mem_rd`.
  - Next state: if the other port's req is high, go directly to GRANT_other and capture its request (back-to-back). Otherwise go to IDLE and deassert `mem_re`/`mem_we`.
  - Port x's own `x_req` in its ack cycle is the completed request and is ignored.
- **In GRANT_x with `mem_valid` = 0:**
  - `cnt` increments.
  - If `cnt == TIMEOUT-1`, abort: `x_ack = 1` with `x_rd = 0`, set `timeout_err = 1`, go to IDLE, deassert `mem_re`/`mem_we`.
  - `mem_valid` arriving in that same cycle takes precedence: normal completion, no error.
- **Read data and acks:**
  - `i_rd` and `d_rd` both equal `mem_rd` except in an abort cycle, when the aborted port's rd is 0.
  - `i_ack` and `d_ack` are never high together.
  - No ack is ever issued to a non-granted port.
- **Reset** (`reset == 0` at a clock edge, including mid-transaction):
  - State goes to IDLE; `last_grant` = I, so D wins the first tie.
  - `cnt`, `mem_re`, `mem_we`, `mem_a`, `mem_wd` and `timeout_err` go to 0.
  - `busy`, `i_ack` and `d_ack` are 0.
  - A stale `mem_valid` after reset is ignored by the IDLE rule.

## Timing
- Request sampled in IDLE at edge t: `mem_re`/`mem_we` high from cycle t+1.
- Ack is in the same cycle `mem_valid` is high. Total latency = 1 + memory latency.
- Back-to-back handoff: the second port's enables are asserted in the cycle right after the first port's ack. There are zero idle cycles; memory sees its IDLE state with the new request.
- A single-port transaction returns `mem_re`/`mem_we` to 0 for at least one cycle before that port can be granted again. Memory therefore never sees a re-trigger from a stale enable.
- The abort ack occurs in the TIMEOUT-th cycle of the grant.
- `busy` is 1 exactly in GRANT states.
- `timeout_err` is registered and rises the cycle after the abort.

## Test plan
- **Single read:** `i_req`, `i_we=0`, `i_a=0x100`; stub asserts `mem_valid` 4 cycles after `mem_re` with `mem_rd` = pattern P. Required: `mem_a=0x100`, `mem_re=1` at t+1; `i_ack=1` and `i_rd=P` in the `mem_valid` cycle; `d_ack` stays 0; IDLE and `mem_re=0` next cycle.
- **Single write:** `d_req`, `d_we=1`, `d_a=0x2040`, `d_wd=W`. Required: `mem_we=1`, `mem_re=0`, `mem_wd=W` held constant until `mem_valid`; `d_ack` pulses once.
- **Tie after reset:** both reqs high in the same cycle. Required: D served first. I is granted in the cycle after `d_ack` with no idle gap. A third simultaneous tie then goes to D again.
- **Alternation:** both ports requesting continuously for 6 transactions. Required: grants alternate D, I, D, I, D, I; `i_ack` and `d_ack` are never high together.
- **Timeout:** `TIMEOUT=8`, stub never asserts `mem_valid`. Required: `i_ack` in the 8th grant cycle with `i_rd=0`; `timeout_err=1` from the next cycle and stays 1 until reset. A variant with `mem_valid` in exactly the 8th grant cycle must complete normally with `timeout_err=0`.
- **Reset mid-grant:** drop `reset` 2 cycles into GRANT_D. Required: next cycle all outputs 0 and state IDLE. A late `mem_valid` after reset produces no ack.
